// File: rtl/imem_load_arbiter.sv
// Single-port instruction-memory owner: sequences the boot-time program load, then arbitrates
// fetch reads against loader hot-patch writes. Optional macro IMEM_BOUNDS_CHECK_EN drops out-of-range loader words.
module imem_load_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   load_count,
  output logic              err
);

  localparam int STREAK_W = $clog2(MAX_BURST + 1);
  localparam logic [STREAK_W-1:0] BURST_LIMIT = STREAK_W'(MAX_BURST);
  localparam logic [ADDR_W:0]     DEPTH       = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  err_q, err_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;

  logic                  ld_win;
  logic                  f_win;
  logic                  ld_aligned;
  logic                  ld_in_range;
  logic                  ld_ok;
  logic [ADDR_W-1:0]     ld_word;
  logic [ADDR_W-1:0]     f_word;
  logic                  unused_bits;

  assign ld_word    = ld_addr[ADDR_W+1:2];
  assign f_word     = f_addr[ADDR_W+1:2];
  assign ld_aligned = (ld_addr[1:0] == 2'b00);

`ifdef IMEM_BOUNDS_CHECK_EN
  assign ld_in_range = (ld_addr[31:ADDR_W+2] == '0);
`else
  // Upper address bits are ignored: the word address wraps modulo the memory depth.
  assign ld_in_range = 1'b1;
`endif

  assign ld_ok       = ld_aligned & ld_in_range;
  assign unused_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0], ld_addr[31:ADDR_W+2]};

  // Port ownership and memory drive, decoded from registered state only.
  always_comb begin
    ld_win    = 1'b0;
    f_win     = 1'b0;
    ld_ready  = 1'b0;
    f_gnt     = 1'b0;
    f_stall   = 1'b1;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        ld_win   = ld_valid;
      end
      ST_RUN: begin
        // Loader wins conflicts until it has held the port MAX_BURST times in a row.
        if (ld_valid && (!f_req || streak_q != BURST_LIMIT)) begin
          ld_win = 1'b1;
        end else begin
          f_win = f_req;
        end
        ld_ready = ld_win;
        f_gnt    = f_win;
        f_stall  = f_req & ~f_win;
      end
      default: ;
    endcase
    if (ld_win) begin
      mem_en = ld_ok;
      mem_we = ld_ok;
      if (ld_ok) begin
        mem_addr  = ld_word;
        mem_wdata = ld_data;
      end
    end else if (f_win) begin
      mem_en   = 1'b1;
      mem_addr = f_word;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    streak_d = '0;
    if (ld_win) begin
      if (ld_ok) begin
        if (count_q != DEPTH) begin
          count_d = count_q + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
    case (state_q)
      ST_LOAD: begin
        if (ld_valid && ld_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (f_req && ld_win) begin
          streak_d = streak_q + 1'b1;
        end
        // A reload overrides this cycle's bookkeeping, though the granted access still happens.
        if (boot_start) begin
          state_d  = ST_LOAD;
          count_d  = '0;
          err_d    = 1'b0;
          streak_d = '0;
        end
      end
      default: begin
        if (boot_start) begin
          state_d = ST_LOAD;
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      err_q    <= err_d;
      streak_q <= streak_d;
    end
  end

  assign state      = state_q;
  assign load_count = count_q;
  assign err        = err_q;

endmodule
